// File: rtl/ex_muldiv.sv
// ---------------------------------------------------------------------------
// ex_muldiv
//   EX-stage multiply/divide unit that owns the architectural HI/LO registers.
//   It takes the forwarded rs/rt operands for MULT, MULTU, DIV, DIVU, MTHI and
//   MTLO. While a multiply or divide is in flight, busy_o stalls the pipeline.
//   Multiply is a counted fixed-latency operation (MUL_CYCLES cycles). Divide
//   is a 32-step restoring divider, followed by one sign-fix cycle.
//
// Ports
//   clk       in   1   clock
//   rst       in   1   synchronous active-high reset
//   start_i   in   1   operation valid in EX this cycle
//   op_i      in   3   000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU,
//                      101 MTHI, 110 MTLO, 111 none
//   op_a_i    in   32  rs operand (dividend / multiplicand / MTxx source)
//   op_b_i    in   32  rt operand (divisor / multiplier)
//   cancel_i  in   1   flush: abort any op in flight and drop start_i
//   busy_o    out  1   op in flight; HI/LO not yet valid
//   done_o    out  1   one-cycle pulse after a mul/div writes HI/LO
//   hi_o      out  32  HI register
//   lo_o      out  32  LO register
// ---------------------------------------------------------------------------
module ex_muldiv #(
  parameter int MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic        cancel_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int DATA_W = 32;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  // Magnitude of a two's-complement value. 0x80000000 maps to itself, and
  // that is the correct unsigned magnitude.
  function automatic logic [DATA_W-1:0] abs_val(input logic signed [DATA_W-1:0] v);
    abs_val = v[DATA_W-1] ? DATA_W'(-v) : DATA_W'(v);
  endfunction

  // Re-apply a sign to an unsigned divider result.
  function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] v,
                                                   input logic neg);
    apply_sign = neg ? (~v + DATA_W'(1)) : v;
  endfunction

  // Control state
  state_t      r_state;
  state_t      w_state_nxt;
  logic [5:0]  r_cnt;
  logic [5:0]  w_cnt_nxt;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  // Strobes decoded by the FSM
  logic w_acc_mul;
  logic w_acc_div;
  logic w_wr_mthi;
  logic w_wr_mtlo;
  logic w_mul_wr;
  logic w_div_step;
  logic w_div_wr;

  // Datapath registers (no reset: only consumed under control of r_state)
  logic signed [31:0] r_mul_a_p0;
  logic signed [31:0] r_mul_b_p0;
  logic               r_mul_sgn_p0;
  logic [31:0]        r_div_rem_p0;
  logic [31:0]        r_div_quot_p0;
  logic [31:0]        r_div_dvsr_p0;
  logic [31:0]        r_div_a_p0;
  logic               r_div_negq_p0;
  logic               r_div_negr_p0;
  logic               r_div_dz_p0;

  logic signed [63:0] w_prod_s;
  logic [63:0]        w_prod_u;
  logic [63:0]        w_prod;
  logic [32:0]        w_rem_sh;
  logic [31:0]        w_diff;
  logic               w_ge;
  logic               w_op_signed;
  logic [31:0]        w_quot_fix;
  logic [31:0]        w_rem_fix;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= w_mul_wr | w_div_wr;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state and strobes. A cancel overrides everything, including a
  // completion on the same edge, so a flushed op never writes HI/LO.
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_acc_mul   = 1'b0;
    w_acc_div   = 1'b0;
    w_wr_mthi   = 1'b0;
    w_wr_mtlo   = 1'b0;
    w_mul_wr    = 1'b0;
    w_div_step  = 1'b0;
    w_div_wr    = 1'b0;
    if (cancel_i) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start_i) begin
            unique case (op_i)
              OP_MULT, OP_MULTU: begin
                w_acc_mul   = 1'b1;
                w_state_nxt = S_MUL;
                w_cnt_nxt   = 6'(MUL_CYCLES);
              end
              OP_DIV, OP_DIVU: begin
                w_acc_div   = 1'b1;
                w_state_nxt = S_DIV;
                w_cnt_nxt   = 6'd32;
              end
              OP_MTHI: w_wr_mthi = 1'b1;
              OP_MTLO: w_wr_mtlo = 1'b1;
              default: ;
            endcase
          end
        end
        S_MUL: begin
          w_cnt_nxt = r_cnt - 6'd1;
          if (r_cnt == 6'd1) begin
            w_mul_wr    = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        S_DIV: begin
          w_div_step = 1'b1;
          w_cnt_nxt  = r_cnt - 6'd1;
          if (r_cnt == 6'd1) w_state_nxt = S_FIX;
        end
        S_FIX: begin
          w_div_wr    = 1'b1;
          w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Operand capture and divider iteration
  // -------------------------------------------------------------------------
  assign w_op_signed = (op_i == OP_DIV);

  always_ff @(posedge clk) begin
    if (w_acc_mul) begin
      r_mul_a_p0   <= $signed(op_a_i);
      r_mul_b_p0   <= $signed(op_b_i);
      r_mul_sgn_p0 <= (op_i == OP_MULT);
    end
    if (w_acc_div) begin
      r_div_rem_p0  <= '0;
      r_div_quot_p0 <= w_op_signed ? abs_val($signed(op_a_i)) : op_a_i;
      r_div_dvsr_p0 <= w_op_signed ? abs_val($signed(op_b_i)) : op_b_i;
      r_div_a_p0    <= op_a_i;
      r_div_negq_p0 <= w_op_signed & (op_a_i[31] ^ op_b_i[31]);
      r_div_negr_p0 <= w_op_signed & op_a_i[31];
      r_div_dz_p0   <= (op_b_i == 32'd0);
    end else if (w_div_step) begin
      r_div_rem_p0  <= w_ge ? w_diff : w_rem_sh[31:0];
      r_div_quot_p0 <= {r_div_quot_p0[30:0], w_ge};
    end
  end

  // One restoring step. The partial remainder is always below the divisor,
  // so the 32-bit difference is exact whenever the trial does not underflow.
  assign w_rem_sh = {r_div_rem_p0, r_div_quot_p0[31]};
  assign w_ge     = (w_rem_sh >= {1'b0, r_div_dvsr_p0});
  assign w_diff   = w_rem_sh[31:0] - r_div_dvsr_p0;

  // -------------------------------------------------------------------------
  // Result formation: product and sign-fixed quotient/remainder
  // -------------------------------------------------------------------------
  always_comb begin
    w_prod_s = $signed({{32{r_mul_a_p0[31]}}, r_mul_a_p0})
             * $signed({{32{r_mul_b_p0[31]}}, r_mul_b_p0});
    w_prod_u = {32'd0, r_mul_a_p0} * {32'd0, r_mul_b_p0};
    w_prod   = r_mul_sgn_p0 ? w_prod_s : w_prod_u;
  end

  assign w_quot_fix = apply_sign(r_div_quot_p0, r_div_negq_p0);
  assign w_rem_fix  = apply_sign(r_div_rem_p0, r_div_negr_p0);

  // -------------------------------------------------------------------------
  // Architectural HI/LO
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      if (w_wr_mthi) r_hi <= op_a_i;
      if (w_wr_mtlo) r_lo <= op_a_i;
      if (w_mul_wr) begin
        r_hi <= w_prod[63:32];
        r_lo <= w_prod[31:0];
      end
      if (w_div_wr) begin
        // Divide by zero leaves the dividend in HI and all ones in LO.
        r_hi <= r_div_dz_p0 ? r_div_a_p0 : w_rem_fix;
        r_lo <= r_div_dz_p0 ? 32'hFFFF_FFFF : w_quot_fix;
      end
    end
  end

  assign busy_o = r_busy;
  assign done_o = r_done;
  assign hi_o   = r_hi;
  assign lo_o   = r_lo;

endmodule
